// File: rtl/alu_result_stage.sv
// alu_result_stage: opcode-selected result register with accumulator feedback,
// flags, sticky error, op counter and a one-entry valid/ready output buffer.
module alu_result_stage #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] not_res,
   input  logic [WIDTH-1:0] and_res,
   input  logic [WIDTH-1:0] or_res,
   input  logic [WIDTH-1:0] xor_res,
   input  logic [WIDTH-1:0] add_res,
   input  logic [WIDTH-1:0] sub_res,
   input  logic             add_carry,
   input  logic             sub_borrow,
   input  logic [2:0]       op,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] result,
   output logic             flag_zero,
   output logic             flag_neg,
   output logic             flag_carry,
   output logic             err,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] acc,
   output logic [CNT_W-1:0] op_count
);

   localparam logic [2:0] OP_NOP = 3'b000;
   localparam logic [2:0] OP_ADD = 3'b001;
   localparam logic [2:0] OP_SUB = 3'b010;
   localparam logic [2:0] OP_AND = 3'b011;
   localparam logic [2:0] OP_OR  = 3'b100;
   localparam logic [2:0] OP_XOR = 3'b101;
   localparam logic [2:0] OP_NOT = 3'b110;
   localparam logic [2:0] OP_CLR = 3'b111;

   typedef enum logic {EMPTY, FULL} state_t;

   state_t           state;
   state_t           state_nx;
   logic             accept;
   logic [WIDTH-1:0] sel;
   logic             carry_src;

   assign out_valid = (state == FULL);
   assign in_ready  = !out_valid || out_ready;
   assign accept    = in_valid && in_ready;

   always_comb begin
      sel       = '0;
      carry_src = 1'b0;
      unique case (op)
         OP_NOP: sel = acc;
         OP_ADD: begin
            sel       = add_res;
            carry_src = add_carry;
         end
         OP_SUB: begin
            sel       = sub_res;
            carry_src = sub_borrow;
         end
         OP_AND: sel = and_res;
         OP_OR:  sel = or_res;
         OP_XOR: sel = xor_res;
         OP_NOT: sel = not_res;
         OP_CLR: sel = '0;
         default: sel = '0;
      endcase
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         EMPTY: if (accept) state_nx = FULL;
         FULL:  if (out_ready && !accept) state_nx = EMPTY;
         default: state_nx = EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= EMPTY;
      else        state <= state_nx;
   end

   // acc/result only move on accept, so a stalled beat stays bit-stable
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc        <= '0;
         result     <= '0;
         flag_zero  <= 1'b0;
         flag_neg   <= 1'b0;
         flag_carry <= 1'b0;
         err        <= 1'b0;
         op_count   <= '0;
      end else if (accept) begin
         acc        <= sel;
         result     <= sel;
         flag_zero  <= (sel == '0);
         flag_neg   <= sel[WIDTH-1];
         flag_carry <= carry_src;
         if (op == OP_CLR) err <= 1'b0;
         else if (carry_src) err <= 1'b1;
         op_count   <= op_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_alu_result_stage.sv
// tb_alu_result_stage: scoreboard bench; expected beats queued on accept,
// checked while presented and popped when consumed.
module tb_alu_result_stage;

   localparam int W = 16;
   localparam int C = 8;

   typedef struct packed {
      logic [W-1:0] res;
      logic         z;
      logic         n;
      logic         c;
      logic         e;
      logic [C-1:0] cnt;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [W-1:0] not_res, and_res, or_res, xor_res, add_res, sub_res;
   logic         add_carry, sub_borrow;
   logic [2:0]   op;
   logic         in_valid, in_ready;
   logic [W-1:0] result, acc;
   logic         flag_zero, flag_neg, flag_carry, err;
   logic         out_valid, out_ready;
   logic [C-1:0] op_count;

   exp_t         sb[$];
   logic         mfull;
   logic [W-1:0] macc;
   logic         merr;
   logic [C-1:0] mcnt;
   int           errors = 0;
   int           checks = 0;

   always #5 clk = ~clk;

   alu_result_stage #(.WIDTH(W), .CNT_W(C)) dut (
      .clk(clk), .rst_n(rst_n),
      .not_res(not_res), .and_res(and_res), .or_res(or_res),
      .xor_res(xor_res), .add_res(add_res), .sub_res(sub_res),
      .add_carry(add_carry), .sub_borrow(sub_borrow),
      .op(op), .in_valid(in_valid), .in_ready(in_ready),
      .result(result), .flag_zero(flag_zero), .flag_neg(flag_neg),
      .flag_carry(flag_carry), .err(err), .out_valid(out_valid),
      .out_ready(out_ready), .acc(acc), .op_count(op_count)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      mfull = 1'b0;
      macc  = '0;
      merr  = 1'b0;
      mcnt  = '0;
      sb.delete();
   endtask

   // one cycle: drive at negedge, check, then predict the coming edge
   task automatic step(input logic [2:0] o, input logic iv,
                       input logic ordy, input logic [W-1:0] v,
                       input logic cy);
      logic [W-1:0] s;
      logic         cs;
      logic         acc_ok;
      exp_t         e;
      @(negedge clk);
      not_res = W'($urandom); and_res = W'($urandom);
      or_res  = W'($urandom); xor_res = W'($urandom);
      add_res = W'($urandom); sub_res = W'($urandom);
      case (o)
         3'd1: add_res = v;
         3'd2: sub_res = v;
         3'd3: and_res = v;
         3'd4: or_res  = v;
         3'd5: xor_res = v;
         3'd6: not_res = v;
         default: ;
      endcase
      add_carry = cy; sub_borrow = cy;
      op = o; in_valid = iv; out_ready = ordy;
      #1;
      check("out_valid", 32'(out_valid), 32'(mfull));
      check("in_ready", 32'(in_ready), 32'(!mfull || ordy));
      if (mfull) begin
         if (sb.size() == 0) begin
            check("sb_empty", 32'(sb.size()), 32'd1);
         end else begin
            e = sb[0];
            check("result", 32'(result), 32'(e.res));
            check("acc", 32'(acc), 32'(e.res));
            check("flags", {29'd0, flag_zero, flag_neg, flag_carry},
                  {29'd0, e.z, e.n, e.c});
            check("err", 32'(err), 32'(e.e));
            check("op_count", 32'(op_count), 32'(e.cnt));
            if (ordy) void'(sb.pop_front());
         end
      end
      acc_ok = iv && (!mfull || ordy);
      if (acc_ok) begin
         cs = 1'b0;
         case (o)
            3'd0: s = macc;
            3'd1: begin s = add_res; cs = cy; end
            3'd2: begin s = sub_res; cs = cy; end
            3'd3: s = and_res;
            3'd4: s = or_res;
            3'd5: s = xor_res;
            3'd6: s = not_res;
            default: s = '0;
         endcase
         if (o == 3'd7) merr = 1'b0;
         else if (cs) merr = 1'b1;
         macc = s;
         mcnt = mcnt + 8'd1;
         e.res = s; e.z = (s == '0); e.n = s[W-1];
         e.c = cs; e.e = merr; e.cnt = mcnt;
         sb.push_back(e);
         mfull = 1'b1;
      end else if (ordy) begin
         mfull = 1'b0;
      end
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_res"}, 32'(result), 32'd0);
      check({tag, "_acc"}, 32'(acc), 32'd0);
      check({tag, "_vld"}, 32'(out_valid), 32'd0);
      check({tag, "_rdy"}, 32'(in_ready), 32'd1);
      check({tag, "_flg"}, {28'd0, flag_zero, flag_neg, flag_carry, err},
            32'd0);
      check({tag, "_cnt"}, 32'(op_count), 32'd0);
   endtask

   initial begin
      rst_n = 1'b0; op = '0; in_valid = 1'b0; out_ready = 1'b0;
      add_carry = 1'b0; sub_borrow = 1'b0;
      not_res = '0; and_res = '0; or_res = '0;
      xor_res = '0; add_res = '0; sub_res = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 check_zero_outputs("rst0");
      @(negedge clk) rst_n = 1'b1;

      // ADD overflow, then AND keeps sticky err
      step(3'd1, 1, 1, 16'h0000, 1);
      step(3'd3, 1, 1, 16'h00F0, 0);
      // NOT path
      step(3'd6, 1, 1, 16'hFF00, 0);
      // NOP holds acc, CLR clears acc and err
      step(3'd4, 1, 1, 16'h1234, 0);
      step(3'd0, 1, 1, 16'h5555, 1);
      step(3'd7, 1, 1, 16'h5555, 1);
      step(3'd2, 1, 1, 16'h8001, 1);
      step(3'd0, 0, 1, 16'h0, 0);

      // back-pressure: one beat stalls for 5 cycles, then release with op
      step(3'd5, 1, 0, 16'hA5A5, 0);
      repeat (5) step(3'd3, 1, 0, 16'h0F0F, 0);
      step(3'd3, 1, 1, 16'h0F0F, 0);
      step(3'd0, 0, 1, 16'h0, 0);

      // random mix with random back-pressure
      repeat (60) step(3'($urandom), 1'($urandom), 1'($urandom),
                       W'($urandom), 1'($urandom));

      // async reset mid-handshake while a beat is held
      step(3'd1, 1, 0, 16'h8000, 1);
      step(3'd1, 0, 0, 16'h0, 0);
      #2 rst_n = 1'b0;
      #1 check_zero_outputs("rst1");
      model_reset();
      @(negedge clk) rst_n = 1'b1;

      // 256 back-to-back ops: counter wraps, every beat popped once
      repeat (256) step(3'($urandom_range(1, 6)), 1, 1, W'($urandom),
                        1'($urandom));
      step(3'd0, 0, 1, 16'h0, 0);
      check("wrap_cnt", 32'(op_count), 32'd0);
      check("sb_drained", 32'(sb.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
